// File: rtl/lsu.sv
// Load/store unit for the cirno9 core.
// It takes one memory operation per handshake from execute and issues a
// single-beat bus request for it. Load data is aligned and extended before
// writeback. Misaligned accesses, bus errors and response timeouts are each
// reported as a one-cycle exception pulse.
//
// state | meaning
// IDLE  | ready for a new operation from execute
// REQ   | bus request held valid until the bus accepts it
// RSP   | waiting for the response beat, guarded by the timeout counter
`timescale 1ns/1ps
module lsu #(
    parameter int TO_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hs_ex4mem_val,
    output logic        hs_mem4ex_rdy,
    input  logic [31:0] i_mem_adr,
    input  logic [31:0] i_mem_d,
    input  logic        i_mem_ren,
    input  logic        i_mem_wen,
    input  logic [1:0]  i_mem_size,
    input  logic        i_mem_uns,
    input  logic [4:0]  i_rd_idx,
    output logic        o_bus_req_val,
    input  logic        i_bus_req_rdy,
    output logic [31:0] o_bus_adr,
    output logic        o_bus_wen,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wstrb,
    input  logic        i_bus_rsp_val,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_err,
    output logic        o_wb_val,
    output logic [4:0]  o_wb_rd_idx,
    output logic [31:0] o_wb_rd,
    output logic        o_excp_misalign,
    output logic        o_excp_bus,
    output logic [31:0] o_excp_adr
);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_rdy;
    logic [31:0]       r_adr;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [4:0]        r_rd_idx;
    logic [TO_W-1:0]   r_cnt;
    logic [31:0]       r_bus_adr;
    logic              r_bus_wen;
    logic [31:0]       r_bus_wdata;
    logic [3:0]        r_bus_wstrb;
    logic              r_wb_val;
    logic [4:0]        r_wb_rd_idx;
    logic [31:0]       r_wb_rd;
    logic              r_excp_mis;
    logic              r_excp_bus;
    logic [31:0]       r_excp_adr;

    logic              w_accept;
    logic              w_is_op;
    logic              w_misalign;
    logic              w_go;
    logic              w_rsp;
    logic              w_timeout;
    logic [31:0]       w_wdata;
    logic [3:0]        w_wstrb;
    logic [31:0]       w_shift;
    logic [31:0]       w_load;

    assign w_accept   = hs_ex4mem_val && r_rdy;
    assign w_is_op    = i_mem_ren || i_mem_wen;
    assign w_misalign = (i_mem_size == 2'b01 && i_mem_adr[0]) ||
                        (i_mem_size == 2'b10 && i_mem_adr[1:0] != 2'b00) ||
                        (i_mem_size == 2'b11);
    assign w_go       = w_accept && w_is_op && !w_misalign;
    assign w_rsp      = (r_state == RSP) && i_bus_rsp_val;
    // A response in the same cycle as the terminal count still wins.
    assign w_timeout  = (r_state == RSP) && !i_bus_rsp_val && (r_cnt == '1);

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_go) w_next = REQ;
            REQ:     if (i_bus_req_rdy) w_next = RSP;
            RSP:     if (i_bus_rsp_val || w_timeout) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Store lane replication and byte enables; reads drive no strobes.
    always_comb begin
        w_wdata = i_mem_d;
        w_wstrb = 4'b1111;
        case (i_mem_size)
            2'b00: begin
                w_wdata = {4{i_mem_d[7:0]}};
                w_wstrb = 4'b0001 << i_mem_adr[1:0];
            end
            2'b01: begin
                w_wdata = {2{i_mem_d[15:0]}};
                w_wstrb = 4'b0011 << i_mem_adr[1:0];
            end
            default: begin
                w_wdata = i_mem_d;
                w_wstrb = 4'b1111;
            end
        endcase
        if (!i_mem_wen) w_wstrb = 4'b0000;
    end

    // Load alignment and sign/zero extension.
    always_comb begin
        w_shift = i_bus_rdata >> {r_adr[1:0], 3'b000};
        case (r_size)
            2'b00:   w_load = r_uns ? {24'h0, w_shift[7:0]}
                                    : {{24{w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_load = r_uns ? {16'h0, w_shift[15:0]}
                                    : {{16{w_shift[15]}}, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    // State register. Ready is registered from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rdy   <= 1'b1;
        end else begin
            r_state <= w_next;
            r_rdy   <= (w_next == IDLE);
        end
    end

    // Latch the accepted operation and the bus request it produces.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_adr       <= '0;
            r_size      <= '0;
            r_uns       <= 1'b0;
            r_rd_idx    <= '0;
            r_bus_adr   <= '0;
            r_bus_wen   <= 1'b0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
        end else if (w_go) begin
            r_adr       <= i_mem_adr;
            r_size      <= i_mem_size;
            r_uns       <= i_mem_uns;
            r_rd_idx    <= i_rd_idx;
            r_bus_adr   <= {i_mem_adr[31:2], 2'b00};
            r_bus_wen   <= i_mem_wen;
            r_bus_wdata <= w_wdata;
            r_bus_wstrb <= w_wstrb;
        end
    end

    // Response timeout counter: zero outside RSP, counts each RSP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state != RSP) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + {{(TO_W-1){1'b0}}, 1'b1};
        end
    end

    // Load writeback pulse; data and index hold until the next writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_val    <= 1'b0;
            r_wb_rd_idx <= '0;
            r_wb_rd     <= '0;
        end else begin
            r_wb_val <= 1'b0;
            if (w_rsp && !i_bus_err && !r_bus_wen) begin
                r_wb_val    <= 1'b1;
                r_wb_rd_idx <= r_rd_idx;
                r_wb_rd     <= w_load;
            end
        end
    end

    // Exception pulses and the faulting address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_excp_mis <= 1'b0;
            r_excp_bus <= 1'b0;
            r_excp_adr <= '0;
        end else begin
            r_excp_mis <= w_accept && w_is_op && w_misalign;
            r_excp_bus <= (w_rsp && i_bus_err) || w_timeout;
            if (w_accept && w_is_op && w_misalign) begin
                r_excp_adr <= i_mem_adr;
            end else if ((w_rsp && i_bus_err) || w_timeout) begin
                r_excp_adr <= r_adr;
            end
        end
    end

    assign hs_mem4ex_rdy   = r_rdy;
    assign o_bus_req_val   = (r_state == REQ);
    assign o_bus_adr       = r_bus_adr;
    assign o_bus_wen       = r_bus_wen;
    assign o_bus_wdata     = r_bus_wdata;
    assign o_bus_wstrb     = r_bus_wstrb;
    assign o_wb_val        = r_wb_val;
    assign o_wb_rd_idx     = r_wb_rd_idx;
    assign o_wb_rd         = r_wb_rd;
    assign o_excp_misalign = r_excp_mis;
    assign o_excp_bus      = r_excp_bus;
    assign o_excp_adr      = r_excp_adr;

endmodule
